// File: rtl/acc_sequencer_if.sv
// Bundle of the accumulator sequencer's command handshake, array/write-back
// status inputs and accumulator/array control outputs.
interface acc_sequencer_if #(
    parameter int KT_WIDTH = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [KT_WIDTH-1:0] cmd_k_tiles;
    logic                cmd_bias;
    logic                cmd_relu;
    logic                cmd_buf_sel;
    logic                sys2d_stall;
    logic                wb_ready;
    logic                sys2d_en;
    logic                acc_en;
    logic                acc_clear_en;
    logic                bias_load_en;
    logic                clear_buffer;
    logic                relu_en;
    logic                acc_buffer_sel;
    logic                write_back;
    logic                acc_data_oen;
    logic                done;
    logic                busy;

    // master issues commands and observes controls; slave is the sequencer
    modport master (
        output cmd_valid, cmd_k_tiles, cmd_bias, cmd_relu, cmd_buf_sel,
               sys2d_stall, wb_ready,
        input  cmd_ready, sys2d_en, acc_en, acc_clear_en, bias_load_en,
               clear_buffer, relu_en, acc_buffer_sel, write_back,
               acc_data_oen, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_k_tiles, cmd_bias, cmd_relu, cmd_buf_sel,
               sys2d_stall, wb_ready,
        output cmd_ready, sys2d_en, acc_en, acc_clear_en, bias_load_en,
               clear_buffer, relu_en, acc_buffer_sel, write_back,
               acc_data_oen, done, busy
    );
endinterface

// File: rtl/acc_sequencer.sv
// Tile-command sequencer: clears the accumulator, optionally preloads bias,
// accumulates K tiles, drains the array skew and writes back the rows.
module acc_sequencer #(
    parameter int SYS_ARRAY_HEIGHT = 16,
    parameter int SYS_ARRAY_WIDTH  = 16,
    parameter int ACC_LATENCY      = 2,
    parameter int KT_WIDTH         = 8
) (
    input  logic         clk,
    input  logic         reset,
    acc_sequencer_if.slave bus
);

    localparam int DRAIN_LEN = SYS_ARRAY_WIDTH - 1 + ACC_LATENCY;
    localparam int CNT_MAX   = (SYS_ARRAY_HEIGHT > DRAIN_LEN) ? SYS_ARRAY_HEIGHT : DRAIN_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(SYS_ARRAY_HEIGHT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_BIAS  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DRAIN = 3'd4,
        ST_WBACK = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    row_cnt_r;
    logic [CNT_W-1:0]    row_cnt_s;
    logic [KT_WIDTH-1:0] k_cnt_r;
    logic [KT_WIDTH-1:0] k_cnt_s;
    logic [KT_WIDTH-1:0] k_tiles_r;
    logic                bias_r;
    logic                relu_r;
    logic                buf_sel_r;
    logic                accept_s;
    logic                sys2d_en_s;
    logic                acc_en_s;
    logic                clear_s;
    logic                bias_load_s;
    logic                write_back_s;
    logic                busy_s;

    // State, counters and the command fields captured on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            row_cnt_r <= {CNT_W{1'b0}};
            k_cnt_r   <= {KT_WIDTH{1'b0}};
            k_tiles_r <= {KT_WIDTH{1'b0}};
            bias_r    <= 1'b0;
            relu_r    <= 1'b0;
            buf_sel_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            row_cnt_r <= row_cnt_s;
            k_cnt_r   <= k_cnt_s;
            if (accept_s) begin
                k_tiles_r <= (bus.cmd_k_tiles == {KT_WIDTH{1'b0}}) ? KT_WIDTH'(1) : bus.cmd_k_tiles;
                bias_r    <= bus.cmd_bias;
                relu_r    <= bus.cmd_relu;
                buf_sel_r <= bus.cmd_buf_sel;
            end else begin
                k_tiles_r <= k_tiles_r;
                bias_r    <= bias_r;
                relu_r    <= relu_r;
                buf_sel_r <= buf_sel_r;
            end
        end
    end

    // Next-state, counter stepping and per-state control decode
    always_comb begin
        state_s      = state_r;
        row_cnt_s    = row_cnt_r;
        k_cnt_s      = k_cnt_r;
        accept_s     = 1'b0;
        sys2d_en_s   = 1'b0;
        acc_en_s     = 1'b0;
        clear_s      = 1'b0;
        bias_load_s  = 1'b0;
        write_back_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    accept_s = 1'b1;
                    state_s  = ST_CLEAR;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clear_s   = 1'b1;
                row_cnt_s = {CNT_W{1'b0}};
                k_cnt_s   = {KT_WIDTH{1'b0}};
                state_s   = bias_r ? ST_BIAS : ST_ACCUM;
            end
            ST_BIAS: begin
                if (!bus.sys2d_stall) begin
                    bias_load_s = 1'b1;
                    sys2d_en_s  = 1'b1;
                    state_s     = ST_ACCUM;
                end else begin
                    state_s     = ST_BIAS;
                end
            end
            ST_ACCUM: begin
                if (!bus.sys2d_stall) begin
                    acc_en_s   = 1'b1;
                    sys2d_en_s = 1'b1;
                    if (row_cnt_r == ROW_LAST) begin
                        row_cnt_s = {CNT_W{1'b0}};
                        if (k_cnt_r == (k_tiles_r - KT_WIDTH'(1))) begin
                            k_cnt_s = {KT_WIDTH{1'b0}};
                            state_s = ST_DRAIN;
                        end else begin
                            k_cnt_s = k_cnt_r + KT_WIDTH'(1);
                        end
                    end else begin
                        row_cnt_s = row_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (!bus.sys2d_stall) begin
                    sys2d_en_s = 1'b1;
                    if (row_cnt_r == DRAIN_LAST) begin
                        row_cnt_s = {CNT_W{1'b0}};
                        state_s   = ST_WBACK;
                    end else begin
                        row_cnt_s = row_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_WBACK: begin
                // write-back is paced only by the consumer, never by the array stall
                if (bus.wb_ready) begin
                    write_back_s = 1'b1;
                    sys2d_en_s   = 1'b1;
                    if (row_cnt_r == ROW_LAST) begin
                        row_cnt_s = {CNT_W{1'b0}};
                        state_s   = ST_DONE;
                    end else begin
                        row_cnt_s = row_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_WBACK;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                row_cnt_s = {CNT_W{1'b0}};
                k_cnt_s   = {KT_WIDTH{1'b0}};
            end
        endcase
    end

    assign busy_s = (state_r != ST_IDLE);

    // Reset masks every output in the cycle it is asserted
    assign bus.cmd_ready      = (state_r == ST_IDLE) & ~reset;
    assign bus.busy           = busy_s & ~reset;
    assign bus.done           = (state_r == ST_DONE) & ~reset;
    assign bus.sys2d_en       = sys2d_en_s & ~reset;
    assign bus.acc_en         = acc_en_s & ~reset;
    assign bus.acc_clear_en   = clear_s & ~reset;
    assign bus.clear_buffer   = clear_s & ~reset;
    assign bus.bias_load_en   = bias_load_s & ~reset;
    assign bus.write_back     = write_back_s & ~reset;
    assign bus.acc_data_oen   = write_back_s & ~reset;
    assign bus.relu_en        = relu_r & busy_s & ~reset;
    assign bus.acc_buffer_sel = buf_sel_r & busy_s & ~reset;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: stimulus queues the expected per-command
// profile, a negedge monitor measures the DUT and compares on each done.
module tb_acc_sequencer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    typedef struct {
        int done_lat;
        int acc_cnt;
        int first_acc;
        int wb_cnt;
        int first_wb;
        int bias_cnt;
        int sys_cnt;
        int relu_cnt;
        int buf_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   accepts;

    acc_sequencer_if #(.KT_WIDTH(8)) bus ();

    acc_sequencer #(
        .SYS_ARRAY_HEIGHT(16),
        .SYS_ARRAY_WIDTH (16),
        .ACC_LATENCY     (2),
        .KT_WIDTH        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return {20'd0, bus.cmd_ready, bus.busy, bus.done, bus.sys2d_en, bus.acc_en,
                bus.acc_clear_en, bus.bias_load_en, bus.clear_buffer, bus.relu_en,
                bus.acc_buffer_sel, bus.write_back, bus.acc_data_oen};
    endfunction

    // Monitor: measures one command from accept to done
    int  rel, acc_cnt, first_acc, wb_cnt, first_wb, bias_cnt, sys_cnt;
    int  relu_cnt, buf_cnt, clr_cnt, clr_at, viol;
    bit  active;
    exp_t e;

    initial begin
        active  = 1'b0;
        accepts = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (bus.cmd_valid && bus.cmd_ready) begin
                accepts++;
                active = 1'b1;
                rel = 0; acc_cnt = 0; first_acc = -1; wb_cnt = 0; first_wb = -1;
                bias_cnt = 0; sys_cnt = 0; relu_cnt = 0; buf_cnt = 0;
                clr_cnt = 0; clr_at = -1; viol = 0;
            end else if (active) begin
                rel++;
                if (bus.acc_en) begin
                    acc_cnt++;
                    if (first_acc < 0) first_acc = rel;
                end
                if (bus.write_back) begin
                    wb_cnt++;
                    if (first_wb < 0) first_wb = rel;
                end
                if (bus.acc_clear_en) begin
                    clr_cnt++;
                    if (clr_at < 0) clr_at = rel;
                end
                if (bus.bias_load_en) bias_cnt++;
                if (bus.sys2d_en) sys_cnt++;
                if (bus.relu_en) relu_cnt++;
                if (bus.acc_buffer_sel) buf_cnt++;
                if (bus.sys2d_stall && bus.acc_en) viol++;
                if (bus.sys2d_stall && bus.sys2d_en && !bus.write_back) viol++;
                if (bus.write_back && !bus.wb_ready) viol++;
                if (bus.clear_buffer != bus.acc_clear_en) viol++;
                if (bus.acc_data_oen != bus.write_back) viol++;
                if (!bus.busy || bus.cmd_ready) viol++;
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_latency", rel, e.done_lat);
                        check("acc_en_cycles", acc_cnt, e.acc_cnt);
                        check("first_acc_en", first_acc, e.first_acc);
                        check("write_back_pulses", wb_cnt, e.wb_cnt);
                        check("first_write_back", first_wb, e.first_wb);
                        check("bias_load_cycles", bias_cnt, e.bias_cnt);
                        check("sys2d_en_cycles", sys_cnt, e.sys_cnt);
                        check("relu_en_cycles", relu_cnt, e.relu_cnt);
                        check("buf_sel_cycles", buf_cnt, e.buf_cnt);
                        check("clear_cycles", clr_cnt, 1);
                        check("clear_at", clr_at, 1);
                        check("control_violations", viol, 0);
                    end
                    active = 1'b0;
                end
            end else if (bus.done) begin
                check("done_while_idle", 1, 0);
            end
        end
    end

    // Issues one command and shapes stall / wb_ready per cycle after accept
    task automatic run_cmd(input logic [7:0] k, input logic b, input logic r, input logic s,
                           input int sa, input int sa_len, input int sb, input int sb_len,
                           input bit wb_tog, input bit hold_valid, input int abort_at);
        int  c;
        bit  finished;
        bus.cmd_valid   = 1'b1;
        bus.cmd_k_tiles = k;
        bus.cmd_bias    = b;
        bus.cmd_relu    = r;
        bus.cmd_buf_sel = s;
        @(posedge clk); #1;
        if (!hold_valid) bus.cmd_valid = 1'b0;
        c = 1;
        finished = 1'b0;
        while (!finished && c < 400) begin
            bus.sys2d_stall = ((c >= sa) && (c < sa + sa_len)) || ((c >= sb) && (c < sb + sb_len));
            bus.wb_ready    = wb_tog ? ((c % 2) == 1) : 1'b1;
            if (c == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("outputs_in_reset_cycle", outs(), 0);
                @(posedge clk); #1;
                reset = 1'b0;
                bus.sys2d_stall = 1'b0;
                bus.cmd_valid   = 1'b0;
                @(negedge clk);
                check("outputs_after_reset", outs(), 12'h800);
                @(posedge clk); #1;
                finished = 1'b1;
            end else begin
                @(negedge clk);
                if (bus.done) finished = 1'b1;
                @(posedge clk); #1;
                c++;
            end
        end
        bus.cmd_valid   = 1'b0;
        bus.sys2d_stall = 1'b0;
        bus.wb_ready    = 1'b1;
        check("command_finished_in_budget", int'(finished), 1);
    endtask

    function automatic exp_t mk(input int d, input int a, input int fa, input int w, input int fw,
                                input int bi, input int sy, input int re, input int bu);
        exp_t t;
        t.done_lat = d; t.acc_cnt = a; t.first_acc = fa; t.wb_cnt = w; t.first_wb = fw;
        t.bias_cnt = bi; t.sys_cnt = sy; t.relu_cnt = re; t.buf_cnt = bu;
        return t;
    endfunction

    initial begin
        int dones;
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_k_tiles = 8'd0;
        bus.cmd_bias    = 1'b0;
        bus.cmd_relu    = 1'b0;
        bus.cmd_buf_sel = 1'b0;
        bus.sys2d_stall = 1'b0;
        bus.wb_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", outs(), 12'h800);
        @(posedge clk); #1;

        // k=1, no bias: clear@1, acc 2-17, drain 18-34, wb 35-50, done 51
        exp_q.push_back(mk(51, 16, 2, 16, 35, 0, 49, 0, 0));
        run_cmd(8'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, -1);

        // k=3, bias, relu, buf_sel: bias@2, acc 3-50, wb 68-83, done 84
        exp_q.push_back(mk(84, 48, 3, 16, 68, 1, 82, 84, 84));
        run_cmd(8'd3, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, -1);

        // stall 5 cycles in ACCUM (6-10) and 3 in DRAIN (28-30): +8 cycles
        exp_q.push_back(mk(59, 16, 2, 16, 43, 0, 49, 0, 0));
        run_cmd(8'd1, 1'b0, 1'b0, 1'b0, 6, 5, 28, 3, 1'b0, 1'b0, -1);

        // wb_ready high on odd cycles only: rows at 35,37,..,65, done 66
        exp_q.push_back(mk(66, 16, 2, 16, 35, 0, 49, 0, 0));
        run_cmd(8'd1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, -1);

        // k=0 acts as 1; cmd_valid held through busy
        exp_q.push_back(mk(51, 16, 2, 16, 35, 0, 49, 0, 51));
        run_cmd(8'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b1, -1);

        // reset in ACCUM at cycle 8: abort, no done
        run_cmd(8'd1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 8);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("no_done_after_abort", dones, 0);
        @(posedge clk); #1;

        // k=2, relu only: acc 2-33, drain 34-50, wb 51-66, done 67
        exp_q.push_back(mk(67, 32, 2, 16, 51, 0, 65, 67, 0));
        run_cmd(8'd2, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, -1);

        repeat (3) @(posedge clk);
        check("pending_expectations", exp_q.size(), 0);
        check("accept_count", accepts, 7);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
